// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Desc     : Shared FSM encoding, digit count, time-entry limits and helpers.
// Revision : 1.0
// ============================================================================
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } entry_state_t;

  localparam int         NUM_DIGITS           = 6;
  localparam logic [3:0] HOUR_TENS_MAX        = 4'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_20 = 4'd3;
  localparam logic [3:0] MINSEC_TENS_MAX      = 4'd5;

  // Units digits need no check: keys only ever produce 0-9.
  function automatic logic time_in_range(input logic [23:0] bcd);
    logic [3:0] h1, h0, m1, s1;
    logic       hour_ok;
    h1 = bcd[23:20];
    h0 = bcd[19:16];
    m1 = bcd[15:12];
    s1 = bcd[7:4];
    hour_ok = (h1 < HOUR_TENS_MAX) ||
              ((h1 == HOUR_TENS_MAX) && (h0 <= HOUR_UNITS_MAX_AT_20));
    return hour_ok && (m1 <= MINSEC_TENS_MAX) && (s1 <= MINSEC_TENS_MAX);
  endfunction

  function automatic logic is_onehot10(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] onehot_index(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_time_entry_debounce.sv
`default_nettype none
// ============================================================================
// Module   : keypad_debounce
// Desc     : Keypad synchronizer, debouncer and single-shot press detector.
// Revision : 1.0
// ============================================================================
module keypad_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] keypad,
  output logic       key_strobe,
  output logic [3:0] key_code
);

  localparam int                  c_CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

  logic [9:0]         r_sync1, r_sync2;
  logic [9:0]         r_cand, r_stable;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_armed;
  logic               w_accept, w_press;

  // r_armed stays low after reset until an all-zero vector is accepted, so a
  // key held through reset is never reported.
  assign w_accept = (r_sync2 == r_cand) && (r_cnt == c_CNT_LAST);
  assign w_press  = w_accept && r_armed && (r_stable == 10'd0) && is_onehot10(r_cand);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 10'd0;
      r_sync2    <= 10'd0;
      r_cand     <= 10'd0;
      r_stable   <= 10'd0;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      key_strobe <= 1'b0;
      key_code   <= 4'd0;
    end else begin
      r_sync1 <= keypad;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= c_CNT_ONE;
      end else if (r_cnt != c_CNT_LAST) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      if (w_accept) begin
        r_stable <= r_cand;
        if (r_cand == 10'd0) r_armed <= 1'b1;
      end
      key_strobe <= w_press;
      if (w_press) key_code <= onehot_index(r_cand);
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_time_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_time_entry
// Desc     : Collects six keypad digits into BCD HH:MM:SS and range-checks it.
// Revision : 1.0
// ============================================================================
module keypad_time_entry
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int TIMEOUT_CYC  = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [9:0]  keypad,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic [23:0] entry_bcd,
  output logic [2:0]  digit_cnt,
  output logic        entry_valid,
  output logic        entry_err
);

  localparam int                 c_TO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST    = c_TO_W'(TIMEOUT_CYC - 1);
  localparam logic [c_TO_W-1:0]  c_TO_ONE     = c_TO_W'(1);
  localparam logic [2:0]         c_LAST_DIGIT = 3'(NUM_DIGITS - 1);

  keypad_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .keypad     (keypad),
    .key_strobe (key_strobe),
    .key_code   (key_code)
  );

  entry_state_t       r_state, w_state_nxt;
  logic [c_TO_W-1:0]  r_idle, w_idle_nxt;
  logic [23:0]        w_bcd_nxt;
  logic [2:0]         w_cnt_nxt;
  logic               w_valid_nxt, w_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idle      <= '0;
      entry_bcd   <= 24'd0;
      digit_cnt   <= 3'd0;
      entry_valid <= 1'b0;
      entry_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idle      <= w_idle_nxt;
      entry_bcd   <= w_bcd_nxt;
      digit_cnt   <= w_cnt_nxt;
      entry_valid <= w_valid_nxt;
      entry_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle;
    w_bcd_nxt   = entry_bcd;
    w_cnt_nxt   = digit_cnt;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    // Dropping enable wins over everything, including a pending check result.
    if (!enable) begin
      w_state_nxt = IDLE;
      w_idle_nxt  = '0;
      w_bcd_nxt   = 24'd0;
      w_cnt_nxt   = 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_idle_nxt  = '0;
          w_bcd_nxt   = 24'd0;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = COLLECT;
        end
        COLLECT: begin
          if (key_strobe) begin
            w_bcd_nxt  = {entry_bcd[19:0], key_code};
            w_cnt_nxt  = digit_cnt + 3'd1;
            w_idle_nxt = '0;
            if (digit_cnt == c_LAST_DIGIT) w_state_nxt = CHECK;
          end else if (digit_cnt != 3'd0) begin
            if (r_idle == c_TO_LAST) begin
              w_err_nxt  = 1'b1;
              w_bcd_nxt  = 24'd0;
              w_cnt_nxt  = 3'd0;
              w_idle_nxt = '0;
            end else begin
              w_idle_nxt = r_idle + c_TO_ONE;
            end
          end
        end
        CHECK: begin
          if (time_in_range(entry_bcd)) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_err_nxt   = 1'b1;
            w_bcd_nxt   = 24'd0;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = COLLECT;
          end
        end
        DONE: begin
          if (key_strobe) begin
            w_bcd_nxt   = {20'd0, key_code};
            w_cnt_nxt   = 3'd1;
            w_idle_nxt  = '0;
            w_state_nxt = COLLECT;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_time_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_time_entry
// Desc     : Self-checking bench for keypad_time_entry with a digit-queue model.
// Revision : 1.0
// ============================================================================
module tb_keypad_time_entry;

  localparam int DEB = 20;
  localparam int TMO = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  keypad = 10'd0;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [23:0] entry_bcd;
  logic [2:0]  digit_cnt;
  logic        entry_valid, entry_err;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int n_strobe = 0, n_valid = 0, n_err = 0, n_both = 0;
  int last_strobe = -1, last_valid = -1, last_err = -1;
  logic [3:0] last_code = 4'd0;

  int  model_q[$];
  bit  model_done;

  keypad_time_entry #(
    .DEBOUNCE_CYC (DEB),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .keypad      (keypad),
    .key_strobe  (key_strobe),
    .key_code    (key_code),
    .entry_bcd   (entry_bcd),
    .digit_cnt   (digit_cnt),
    .entry_valid (entry_valid),
    .entry_err   (entry_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_strobe) begin
      n_strobe++;
      last_strobe = cyc;
      last_code   = key_code;
    end
    if (entry_valid) begin
      n_valid++;
      last_valid = cyc;
    end
    if (entry_err) begin
      n_err++;
      last_err = cyc;
    end
    if (entry_valid && entry_err) n_both++;
  end

  function automatic logic [23:0] model_bcd();
    int v;
    v = 0;
    foreach (model_q[i]) v = v * 16 + model_q[i];
    return 24'(v);
  endfunction

  function automatic bit model_ok();
    int hh;
    hh = model_q[0] * 10 + model_q[1];
    return (hh <= 23) && (model_q[2] <= 5) && (model_q[4] <= 5);
  endfunction

  task automatic press(input logic [9:0] vec, input int hold, input int gap, output int t_on);
    @(posedge clk); #1;
    keypad = vec;
    t_on   = cyc;
    repeat (hold) @(posedge clk);
    #1 keypad = 10'd0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic clear_by_enable;
    @(posedge clk); #1 enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; keypad = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({key_strobe, key_code, entry_bcd, digit_cnt, entry_valid, entry_err} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got bcd=%h cnt=%0d strobe=%b code=%0d", entry_bcd, digit_cnt, key_strobe, key_code);
    end
    rst_n = 1'b1;
    repeat (DEB + 10) @(posedge clk);
    #1;
    checks++;
    if ({entry_bcd, digit_cnt} !== 27'd0 || n_strobe != 0 || n_valid != 0 || n_err != 0) begin
      errors++;
      $display("FAIL post_reset_idle: bcd=%h cnt=%0d strobes=%0d want 0", entry_bcd, digit_cnt, n_strobe);
    end
  endtask

  task automatic test_valid_entry;
    int t, s0, v0, e0;
    logic [9:0] vec;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    v0 = n_valid; e0 = n_err;
    for (int d = 1; d <= 6; d++) begin
      s0  = n_strobe;
      vec = 10'b1 << d;
      press(vec, 30, 30, t);
      checks++;
      if (n_strobe - s0 != 1 || last_strobe != t + DEB + 2) begin
        errors++;
        $display("FAIL strobe_timing_%0d: strobes=%0d at %0d want 1 at %0d", d, n_strobe - s0, last_strobe, t + DEB + 2);
      end
      checks++;
      if (last_code !== 4'(d)) begin
        errors++;
        $display("FAIL key_code_%0d: got %0d want %0d", d, last_code, d);
      end
    end
    checks++;
    if (entry_bcd !== 24'h123456 || digit_cnt !== 3'd6) begin
      errors++;
      $display("FAIL entry_123456: got %h cnt %0d want 123456 cnt 6", entry_bcd, digit_cnt);
    end
    checks++;
    if (n_valid - v0 != 1 || last_valid != last_strobe + 2 || n_err != e0) begin
      errors++;
      $display("FAIL valid_pulse: valids=%0d at %0d errs=%0d want 1 at %0d, 0 errs", n_valid - v0, last_valid, n_err - e0, last_strobe + 2);
    end
  endtask

  task automatic test_range_err;
    int t, v0, e0;
    int keys[6] = '{2, 4, 0, 0, 0, 0};
    logic [9:0] vec;
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 6; i++) begin
      vec = 10'b1 << keys[i];
      press(vec, 30, 30, t);
      if (i == 0) begin
        checks++;
        if (entry_bcd !== 24'h000002 || digit_cnt !== 3'd1) begin
          errors++;
          $display("FAIL done_first_digit: got %h cnt %0d want 000002 cnt 1", entry_bcd, digit_cnt);
        end
      end
    end
    checks++;
    if (n_err - e0 != 1 || last_err != last_strobe + 2 || n_valid != v0) begin
      errors++;
      $display("FAIL range_err_pulse: errs=%0d at %0d valids=%0d want 1 at %0d", n_err - e0, last_err, n_valid - v0, last_strobe + 2);
    end
    checks++;
    if (entry_bcd !== 24'd0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL range_err_clear: got %h cnt %0d want 0", entry_bcd, digit_cnt);
    end
  endtask

  task automatic test_bounce;
    int t, s0;
    s0 = n_strobe;
    for (int i = 0; i < 20; i++) begin
      keypad = (i % 2 == 0) ? 10'b0010000000 : 10'd0;
      repeat (5) @(posedge clk);
      #1;
    end
    keypad = 10'b0010000000;
    t = cyc;
    repeat (30) @(posedge clk);
    #1 keypad = 10'd0;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (n_strobe - s0 != 1 || last_strobe != t + DEB + 2 || last_code !== 4'd7) begin
      errors++;
      $display("FAIL bounce_strobe: strobes=%0d at %0d code %0d want 1 at %0d code 7", n_strobe - s0, last_strobe, last_code, t + DEB + 2);
    end
    checks++;
    if (entry_bcd !== 24'h000007 || digit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL bounce_entry: got %h cnt %0d want 000007 cnt 1", entry_bcd, digit_cnt);
    end
  endtask

  task automatic test_multikey;
    int t, s0;
    s0 = n_strobe;
    keypad = 10'b0000101000;
    repeat (30) @(posedge clk);
    #1 keypad = 10'b0000100000;
    repeat (30) @(posedge clk);
    #1 keypad = 10'd0;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (n_strobe != s0 || digit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL multikey_silent: strobes=%0d cnt %0d want 0 cnt 1", n_strobe - s0, digit_cnt);
    end
    press(10'b0000100000, 30, 30, t);
    checks++;
    if (n_strobe - s0 != 1 || last_code !== 4'd5 || entry_bcd !== 24'h000075 || digit_cnt !== 3'd2) begin
      errors++;
      $display("FAIL single_after_multi: strobes=%0d code %0d bcd %h cnt %0d want 1 code 5 bcd 000075 cnt 2", n_strobe - s0, last_code, entry_bcd, digit_cnt);
    end
  endtask

  task automatic test_enable_drop;
    int t, s0, v0, e0;
    press(10'b0000000010, 30, 30, t);
    press(10'b0000000100, 30, 30, t);
    checks++;
    if (entry_bcd !== 24'h007512 || digit_cnt !== 3'd4) begin
      errors++;
      $display("FAIL four_digits: got %h cnt %0d want 007512 cnt 4", entry_bcd, digit_cnt);
    end
    v0 = n_valid; e0 = n_err;
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (entry_bcd !== 24'd0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL enable_drop_clear: got %h cnt %0d want 0", entry_bcd, digit_cnt);
    end
    s0 = n_strobe;
    press(10'b1000000000, 30, 30, t);
    checks++;
    if (n_strobe - s0 != 1 || last_code !== 4'd9 || digit_cnt !== 3'd0 || n_valid != v0 || n_err != e0) begin
      errors++;
      $display("FAIL idle_strobe: strobes=%0d code %0d cnt %0d pulses %0d/%0d want 1 code 9 cnt 0 no pulses", n_strobe - s0, last_code, digit_cnt, n_valid - v0, n_err - e0);
    end
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_timeout;
    int t, e0;
    press(10'b0000000001, 30, 30, t);
    press(10'b1000000000, 30, 30, t);
    e0 = n_err;
    checks++;
    if (entry_bcd !== 24'h000009 || digit_cnt !== 3'd2) begin
      errors++;
      $display("FAIL pre_timeout: got %h cnt %0d want 000009 cnt 2", entry_bcd, digit_cnt);
    end
    while (cyc < last_strobe + TMO) begin
      @(posedge clk); #1;
    end
    checks++;
    if (n_err != e0 || digit_cnt !== 3'd2) begin
      errors++;
      $display("FAIL timeout_early: errs=%0d cnt %0d at %0d want 0 errs cnt 2", n_err - e0, digit_cnt, cyc);
    end
    for (int i = 0; i < 100 && n_err == e0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (n_err - e0 != 1 || last_err != last_strobe + TMO + 1) begin
      errors++;
      $display("FAIL timeout_pulse: errs=%0d at %0d want 1 at %0d", n_err - e0, last_err, last_strobe + TMO + 1);
    end
    checks++;
    if (entry_bcd !== 24'd0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL timeout_clear: got %h cnt %0d want 0", entry_bcd, digit_cnt);
    end
    repeat (TMO + 50) @(posedge clk);
    #1;
    checks++;
    if (n_err - e0 != 1) begin
      errors++;
      $display("FAIL no_timeout_empty: errs=%0d want 1", n_err - e0);
    end
  endtask

  task automatic test_async_reset;
    int t, s0;
    for (int d = 1; d <= 4; d++) press(10'b1 << d, 30, 30, t);
    keypad = 10'b0100000000;
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_strobe, key_code, entry_bcd, digit_cnt, entry_valid, entry_err} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset: got bcd=%h cnt=%0d code=%0d want all 0", entry_bcd, digit_cnt, key_code);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    s0 = n_strobe;
    repeat (60) @(posedge clk);
    #1 keypad = 10'd0;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (n_strobe != s0) begin
      errors++;
      $display("FAIL held_through_reset: strobes=%0d want 0", n_strobe - s0);
    end
    press(10'b0100000000, 30, 30, t);
    checks++;
    if (n_strobe - s0 != 1 || last_code !== 4'd8 || entry_bcd !== 24'h000008 || digit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL repress_after_reset: strobes=%0d code %0d bcd %h cnt %0d want 1 code 8 bcd 000008 cnt 1", n_strobe - s0, last_code, entry_bcd, digit_cnt);
    end
  endtask

  task automatic test_done_restart;
    int t, v0;
    int keys[6] = '{2, 3, 5, 9, 5, 9};
    clear_by_enable();
    v0 = n_valid;
    for (int i = 0; i < 6; i++) press(10'b1 << keys[i], 30, 30, t);
    checks++;
    if (n_valid - v0 != 1 || entry_bcd !== 24'h235959 || digit_cnt !== 3'd6) begin
      errors++;
      $display("FAIL valid_235959: valids=%0d bcd %h cnt %0d want 1 bcd 235959 cnt 6", n_valid - v0, entry_bcd, digit_cnt);
    end
    press(10'b0000000010, 30, 30, t);
    checks++;
    if (entry_bcd !== 24'h000001 || digit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL done_restart: got %h cnt %0d want 000001 cnt 1", entry_bcd, digit_cnt);
    end
  endtask

  task automatic test_random;
    int t, s0, v0, e0, d;
    int hi[6] = '{3, 9, 6, 9, 6, 9};
    bit exp_v, exp_e;
    logic [23:0] exp_bcd;
    int exp_cnt;
    clear_by_enable();
    model_q.delete();
    model_done = 1'b0;
    for (int e = 0; e < 25; e++) begin
      for (int p = 0; p < 6; p++) begin
        d  = $urandom_range(0, hi[p]);
        s0 = n_strobe; v0 = n_valid; e0 = n_err;
        press(10'b1 << d, $urandom_range(24, 40), $urandom_range(22, 40), t);
        if (model_done) begin
          model_q.delete();
          model_done = 1'b0;
        end
        model_q.push_back(d);
        exp_v = 1'b0; exp_e = 1'b0;
        if (model_q.size() == 6) begin
          if (model_ok()) begin
            exp_v = 1'b1;
            model_done = 1'b1;
          end else begin
            exp_e = 1'b1;
            model_q.delete();
          end
        end
        exp_bcd = model_bcd();
        exp_cnt = model_q.size();
        checks++;
        if (n_strobe - s0 != 1 || last_strobe != t + DEB + 2 || last_code !== 4'(d)) begin
          errors++;
          $display("FAIL rand_strobe e%0d p%0d: strobes=%0d at %0d code %0d want 1 at %0d code %0d", e, p, n_strobe - s0, last_strobe, last_code, t + DEB + 2, d);
        end
        checks++;
        if (entry_bcd !== exp_bcd || digit_cnt !== 3'(exp_cnt)) begin
          errors++;
          $display("FAIL rand_entry e%0d p%0d: got %h cnt %0d want %h cnt %0d", e, p, entry_bcd, digit_cnt, exp_bcd, exp_cnt);
        end
        checks++;
        if (n_valid - v0 != int'(exp_v) || n_err - e0 != int'(exp_e)) begin
          errors++;
          $display("FAIL rand_pulse e%0d p%0d: valid=%0d err=%0d want valid=%0d err=%0d", e, p, n_valid - v0, n_err - e0, exp_v, exp_e);
        end
      end
    end
  endtask

  initial begin
    #(100000 * 10);
    errors++;
    $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_valid_entry();
    test_range_err();
    test_bounce();
    test_multikey();
    test_enable_drop();
    test_timeout();
    test_async_reset();
    test_done_restart();
    test_random();
    checks++;
    if (n_both != 0) begin
      errors++;
      $display("FAIL valid_err_overlap: cycles=%0d want 0", n_both);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_time_entry.md
# keypad_time_entry

Front-end input block for the digital clock: turns the raw 10-key keypad (keys 0–9) into debounced, single-shot digit events. It assembles six digits into a BCD HH:MM:SS value, range-checks the result, and hands it to the watch/alarm setting logic with a one-cycle valid or error pulse. It is the input-side counterpart of the display path: the display multiplexes time out to the 7-segment, and this block collects time in from the user while setting mode (dip_sw) is active.

## Interface
- DEBOUNCE_CYC, 20: consecutive stable clk cycles required to accept a keypad change (20 ms at 1 kHz).
- TIMEOUT_CYC, 5000: idle clk cycles allowed between digits of a partial entry before it is aborted.
- clk  input  1  system clock, 1 kHz.
- rst  input  1  reset; asynchronous, active-low.
- enable  input  1  entry mode (driven from dip_sw); high = collect digits.
- keypad  input  10  raw keys, active-high; bit n = digit n; asynchronous to clk.
- key_strobe  output  1  one-cycle pulse per accepted key press (also in IDLE).
- key_code  output  4  binary digit of the last accepted press; held between strobes.
- entry_bcd  output  24  {H1,H0,M1,M0,S1,S0}, 4-bit BCD each; newest digit enters at [3:0].
- digit_cnt  output  3  digits currently in entry_bcd, 0–6.
- entry_valid  output  1  one-cycle pulse: complete entry passed the range check.
- entry_err  output  1  one-cycle pulse: range failure or timeout abort.
- Reset value of every output is 0, and the FSM resets to IDLE.

## Operation
- Input conditioning: a 2-FF synchronizer on keypad, then a debouncer. A candidate vector is accepted only after DEBOUNCE_CYC consecutive identical synchronized samples. Any mismatch restarts the count.
- Press detection: key_strobe fires only when the accepted vector goes from all-zero to exactly one bit set. key_code is loaded with that bit index.
  - Multi-key vectors produce no strobe.
  - Another strobe requires the accepted vector to return to all-zero first.
  - Holding a key produces no auto-repeat.
- FSM states:
  - IDLE: buffer and digit_cnt cleared. Goes to COLLECT on enable=1.
  - COLLECT: on key_strobe, entry_bcd <= {entry_bcd[19:0], key_code} and digit_cnt+1. When digit_cnt reaches 6, go to CHECK.
  - CHECK: evaluate H1≤2, (H1==2 → H0≤3), M1≤5, S1≤5.
    - Pass: entry_valid, go to DONE.
    - Fail: entry_err, clear buffer and digit_cnt, go to COLLECT.
  - DONE: entry_bcd and digit_cnt=6 held. The next key_strobe clears the buffer and loads that digit as the first (digit_cnt=1), then goes to COLLECT.
- Timeout: in COLLECT with digit_cnt 1–5, TIMEOUT_CYC cycles without a strobe → entry_err, buffer and digit_cnt cleared. With digit_cnt=0 there is no timeout.
- enable=0 in any state → IDLE next cycle; buffer cleared, no valid/err pulse. An enable drop during CHECK suppresses that cycle's pulse.
- entry_valid and entry_err are never high in the same cycle.
- Keypad digits are 0–9 only, so no BCD digit can exceed 9.

## Timing
- A key stable high from cycle N gives key_strobe in cycle N+2+DEBOUNCE_CYC.
- A strobe at cycle T updates entry_bcd and digit_cnt at T+1.
- For the sixth digit (strobe at T), CHECK runs at T+1 and entry_valid/entry_err is high in cycle T+2 only.
- Timeout pulse: in the cycle TIMEOUT_CYC after the last strobe's update cycle; buffer cleared in the same edge.
- Asynchronous reset mid-entry: all outputs go to 0 immediately; the debouncer restarts from all-zero, so a key held through reset is not reported until it is released and pressed again.

## Structure
- Shared package clock_pkg holds:
  - FSM encoding (IDLE, COLLECT, CHECK, DONE), 2 bits;
  - NUM_DIGITS=6;
  - limit constants HOUR_TENS_MAX=2, HOUR_UNITS_MAX_AT_20=3, MINSEC_TENS_MAX=5.
- One sub-module, keypad_debounce (synchronizer, debouncer, press detector; outputs key_strobe/key_code). The FSM, buffer and timeout counter stay in keypad_time_entry.

## Test plan
- enable=1, keys 1,2,3,4,5,6 pressed and released cleanly → six strobes; entry_bcd=0x123456, digit_cnt=6; entry_valid one cycle at sixth strobe+2.
- Keys 2,4,0,0,0,0 → entry_err one cycle; entry_bcd=0, digit_cnt=0; the state stays COLLECT.
- Key 7 toggling every 5 cycles for 100 cycles, then stable high → exactly one strobe, at stable-start+2+20; key_code=7.
- Keys 3 and 5 held together, then 5 alone after release → strobe only for 5 alone; keys 0,9 with 5000 idle cycles after 9 → entry_err; digit_cnt 2→0.
- Four digits entered, then enable=0 → next cycle digit_cnt=0, entry_bcd=0, no pulses.
- Same four digits, rst asserted instead → all outputs 0 asynchronously.
- After a valid 235959, press 1 → entry_bcd=0x000001, digit_cnt=1.
